// File: rtl/uart_pkg.sv
// uart_pkg: FSM states and parity constants shared by UART TX/RX.
// UART_TX_PARITY_EN adds the PARITY state and the parity helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

`ifdef UART_TX_PARITY_EN
  // x is the XOR of all data bits; odd parity inverts it
  function automatic logic par_bit(
    input logic x,
    input int   mode
  );
    return x ^ (mode == PARITY_ODD);
  endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: one-cycle tick every CLKS_PER_BIT cycles while run=1.
// Ports: clk, rst_n, restart (zero phase), run (count enable), tick.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter, registered tx line.
// Ports: clk, rst_n, in_valid/in_data/in_ready (frame input),
// tx (serial, idle high), busy, tx_done (end-of-frame pulse).
// Macro UART_TX_PARITY_EN enables the PARITY state / PARITY_MODE.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  import uart_pkg::*;

  localparam int IW = 4;
  localparam logic [IW-1:0] DB_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] SB_LAST = IW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = (PARITY_MODE != PARITY_NONE);
`else
  // parity compiled out: the mode is forced off
  localparam bit HAS_PAR = 1'b0 && (PARITY_MODE != PARITY_NONE);
`endif

  uart_state_e          state;
  uart_state_e          state_nx;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_nx;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] data_sh;
  logic                 ready_q;
  logic                 tx_q;
  logic                 done_q;
  logic                 tx_nx;
  logic                 done_nx;
  logic                 accept;
  logic                 tick;

  // ready_q is only ever set while the FSM sits in IDLE
  assign accept = in_valid && ready_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(accept),
    .run    (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      ready_q <= (state_nx == IDLE);
      tx_q    <= tx_nx;
      done_q  <= done_nx;
      if (accept) begin
        data_q <= in_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) state_nx = START;
      end
      START: begin
        if (tick) state_nx = DATA;
      end
      DATA: begin
`ifdef UART_TX_PARITY_EN
        if (tick && idx == DB_LAST)
          state_nx = HAS_PAR ? PARITY : STOP;
`else
        if (tick && idx == DB_LAST && !HAS_PAR)
          state_nx = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_nx = STOP;
      end
`endif
      STOP: begin
        if (tick && idx == SB_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // bit index restarts in every new state
    if (state_nx != state) begin
      idx_nx = '0;
    end else if (tick) begin
      idx_nx = idx + 1'b1;
    end else begin
      idx_nx = idx;
    end
  end

  // tx is computed from the next state so the flop
  // shows the new bit in the same cycle the state does
  always_comb begin
    data_sh = data_q >> idx_nx;
    done_nx = (state == STOP) && (state_nx == IDLE);
    tx_nx   = 1'b1;
    case (state_nx)
      START:  tx_nx = 1'b0;
      DATA:   tx_nx = data_sh[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_nx = par_bit(^data_q, PARITY_MODE);
`endif
      default: tx_nx = 1'b1;
    endcase
  end

  assign in_ready = ready_q;
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: table vectors, corner sequences and random frames
// checked against a bit-list frame model, over five configurations.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int NL = 5;
  localparam int DB  [NL] = '{8, 8, 8, 8, 5};
  localparam int CPB [NL] = '{4, 4, 4, 4, 3};
  localparam int PM  [NL] = '{0, 1, 2, 0, 1};
  localparam int SB  [NL] = '{1, 1, 1, 2, 2};

`ifdef UART_TX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NL-1:0] in_valid;
  logic [NL-1:0] in_ready;
  logic [NL-1:0] tx;
  logic [NL-1:0] busy;
  logic [NL-1:0] tx_done;
  logic [8:0]    in_data [NL];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < NL; g++) begin : lane
    uart_tx_param #(
      .DATA_BITS   (DB[g]),
      .CLKS_PER_BIT(CPB[g]),
      .PARITY_MODE (PM[g]),
      .STOP_BITS   (SB[g])
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_valid(in_valid[g]),
      .in_data (in_data[g][DB[g]-1:0]),
      .in_ready(in_ready[g]),
      .tx      (tx[g]),
      .busy    (busy[g]),
      .tx_done (tx_done[g])
    );
  end

  // frame bits in time order: bit 0 = start, then data, parity, stops
  typedef struct {
    int         lane;
    logic [8:0] data;
    logic [15:0] bits;
    int         nb;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic int nbits(input int g);
    return 1 + DB[g] + ((PEN && PM[g] != 0) ? 1 : 0) + SB[g];
  endfunction

  function automatic logic [15:0] model_bits(input int g,
                                             input logic [8:0] d);
    logic [15:0] fb = '1;
    logic par = 1'b0;
    int p = 1 + DB[g];
    fb[0] = 1'b0;
    for (int i = 0; i < DB[g]; i++) begin
      fb[1+i] = d[i];
      par ^= d[i];
    end
    if (PEN && PM[g] != 0) fb[p] = (PM[g] == 2) ? ~par : par;
    return fb;
  endfunction

  function automatic logic [63:0] expand(input int g,
                                         input logic [15:0] fb,
                                         input int nb);
    logic [63:0] w = '0;
    for (int k = 0; k < nb * CPB[g]; k++) w[k] = fb[k / CPB[g]];
    return w;
  endfunction

  function automatic logic [63:0] ones(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // called at a negedge; returns at the negedge of the first IDLE cycle
  task automatic run_frame(input int g, input logic [8:0] d,
                           input logic [63:0] ew, input int n,
                           input bit keep, input logic [8:0] nxt,
                           output int waited);
    logic [63:0] aw = '0;
    logic [63:0] ab = '0;
    logic [63:0] ar = '0;
    logic [63:0] ad = '0;
    waited = 0;
    while (!in_ready[g] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready[g]) begin
      chk("ready_timeout", 64'd0, 64'd1);
      return;
    end
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    @(negedge clk);
    if (keep) begin
      in_data[g] = nxt;
    end else begin
      in_valid[g] = 1'b0;
      in_data[g]  = 9'($urandom);
    end
    for (int k = 0; k < n; k++) begin
      aw[k] = tx[g];
      ab[k] = busy[g];
      ar[k] = in_ready[g];
      ad[k] = tx_done[g];
      @(negedge clk);
    end
    chk("wave", aw, ew);
    chk("busy", ab, ones(n));
    chk("ready_low", ar, 64'd0);
    chk("done_early", ad, 64'd0);
    chk("frame_end", 64'({tx_done[g], busy[g], in_ready[g], tx[g]}),
        64'(4'b1011));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int g;
    logic [8:0] d;
    logic seen;

    tbl[0] = '{0, 9'h0A5, 16'h034A, 10};
    tbl[3] = '{3, 9'h000, 16'h0600, 11};
    if (PEN) begin
      tbl[1] = '{1, 9'h0A5, 16'h054A, 11};
      tbl[2] = '{2, 9'h0A5, 16'h074A, 11};
      tbl[4] = '{4, 9'h01F, 16'h01FE, 9};
    end else begin
      tbl[1] = '{1, 9'h0A5, 16'h034A, 10};
      tbl[2] = '{2, 9'h0A5, 16'h034A, 10};
      tbl[4] = '{4, 9'h01F, 16'h00FE, 8};
    end

    rst_n    = 1'b0;
    in_valid = '0;
    for (int i = 0; i < NL; i++) in_data[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'({NL{1'b1}}));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(tx_done), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("ready_rise", 64'(in_ready), 64'({NL{1'b1}}));

    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].lane, tbl[i].data,
                expand(tbl[i].lane, tbl[i].bits, tbl[i].nb),
                tbl[i].nb * CPB[tbl[i].lane], 1'b0, 9'h0, w);
      @(negedge clk);
    end

    // back-to-back with in_valid held high
    run_frame(0, 9'h011, expand(0, model_bits(0, 9'h011), nbits(0)),
              nbits(0) * CPB[0], 1'b1, 9'h022, w);
    run_frame(0, 9'h022, expand(0, model_bits(0, 9'h022), nbits(0)),
              nbits(0) * CPB[0], 1'b0, 9'h0, w);
    chk("b2b_gap", 64'(w), 64'd0);
    repeat (2) @(negedge clk);
    chk("no_queue", 64'(busy[0]), 64'd0);

    // reset in DATA bit 3 (0xF7 has bit 3 low)
    in_valid[0] = 1'b1;
    in_data[0]  = 9'h0F7;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_reset_tx", 64'(tx[0]), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset",
        64'({tx_done[0], busy[0], in_ready[0], tx[0]}), 64'(4'b0001));
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= tx_done[0];
    end
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 64'(in_ready[0]), 64'd0);
    repeat (4) begin
      @(negedge clk);
      seen |= tx_done[0];
    end
    chk("no_done_on_abort", 64'(seen), 64'd0);
    run_frame(0, 9'h03C, expand(0, model_bits(0, 9'h03C), nbits(0)),
              nbits(0) * CPB[0], 1'b0, 9'h0, w);

    // random frames on random lanes
    for (int i = 0; i < 30; i++) begin
      g = $urandom_range(0, NL - 1);
      d = 9'($urandom);
      run_frame(g, d, expand(g, model_bits(g, d), nbits(g)),
                nbits(g) * CPB[g], 1'b0, 9'h0, w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
